ex_cycle: RTL and testbench

EX_CYCLE -- requirements
Module: ex_cycle

---
 rtl/ex_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 117 +++++++++++
 rtl/ex_cycle.sv | 132 +++++++++++++
 tb/tb_ex_cycle.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU operation codes, the
// multiply/divide FSM states and the iteration count.
package ex_pkg;

    localparam int DATA_W    = 32;
    localparam int MD_CYCLES = 32;
    localparam int CNT_W     = $clog2(MD_CYCLES);

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;
    localparam logic [3:0] ALU_MFHI  = 4'b1010;
    localparam logic [3:0] ALU_MFLO  = 4'b1011;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] code);
        return (code == ALU_MULTU) || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle for MD_CYCLES cycles, with the architectural HI/LO registers.
module muldiv_unit
    import ex_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_op,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic                o_busy,
    output logic [DATA_W-1:0]   o_hi,
    output logic [DATA_W-1:0]   o_lo
);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic               w_last;
    logic [CNT_W-1:0]   r_count;

    logic               r_op;
    logic [DATA_W-1:0]  r_opnd;
    logic [DATA_W-1:0]  r_acc_hi;
    logic [DATA_W-1:0]  r_acc_lo;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;

    logic [DATA_W:0]    w_mul_sum;
    logic [DATA_W:0]    w_div_shift;
    logic [DATA_W:0]    w_div_diff;
    logic               w_div_ge;
    logic [DATA_W-1:0]  w_step_hi;
    logic [DATA_W-1:0]  w_step_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_count == CNT_W'(MD_CYCLES - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == BUSY && !w_last) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

    // Multiply: acc_hi accumulates partial sums, acc_lo shifts the multiplier
    // out and the product bits in. Divide: acc_hi is the partial remainder,
    // acc_lo shifts the dividend out and the quotient bits in. A zero divisor
    // always "fits", which yields LO=all ones and HI=dividend with no special case.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = {r_acc_hi, r_acc_lo[DATA_W-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        if (r_op) begin
            w_step_hi = w_div_ge ? w_div_diff[DATA_W-1:0] : w_div_shift[DATA_W-1:0];
            w_step_lo = {r_acc_lo[DATA_W-2:0], w_div_ge};
        end else begin
            w_step_hi = w_mul_sum[DATA_W:1];
            w_step_lo = {w_mul_sum[0], r_acc_lo[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && i_start) begin
            r_op     <= i_op;
            r_opnd   <= i_b;
            r_acc_hi <= '0;
            r_acc_lo <= i_a;
        end else if (r_state == BUSY) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
        end
    end

    assign o_busy = (r_state == BUSY);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/ex_cycle.sv
// Execute stage: combinational ALU, multiply/divide unit hookup and the
// EX/MEM pipeline register; stalls upstream while a MULTU/DIVU iterates.
module ex_cycle
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic [31:0] SignImm,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic [3:0]  ALUControl,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        flush,
    output logic [31:0] ALUres_out,
    output logic [31:0] WriteData,
    output logic [4:0]  des_Reg,
    output logic        zero,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        stall
);

    function automatic logic [31:0] alu_eval(
        input logic [3:0]  code,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] hi,
        input logic [31:0] lo
    );
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        res;
        sa = a;
        sb = b;
        case (code)
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
            ALU_NOR:  res = ~(a | b);
            ALU_MFHI: res = hi;
            ALU_MFLO: res = lo;
            default:  res = 32'd0;
        endcase
        return res;
    endfunction

    logic [31:0] w_opb;
    logic [31:0] w_result;
    logic        w_busy;
    logic        w_start;
    logic        w_bubble;
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    logic [31:0] r_alures_p1;
    logic [31:0] r_wdata_p1;
    logic [4:0]  r_dest_p1;
    logic        r_zero_p1;
    logic        r_branch_p1;
    logic        r_memread_p1;
    logic        r_memwrite_p1;
    logic        r_regwrite_p1;
    logic        r_memtoreg_p1;

    assign w_opb    = ALUSrc ? SignImm : RD2;
    assign w_result = alu_eval(ALUControl, RD1, w_opb, w_hi, w_lo);
    assign w_start  = !w_busy && !flush && is_muldiv(ALUControl);
    // A multiply/divide issue, a flush and every busy cycle all retire as a bubble.
    assign w_bubble = w_busy || flush || is_muldiv(ALUControl);

    muldiv_unit u_md (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_op    (ALUControl == ALU_DIVU),
        .i_a     (RD1),
        .i_b     (w_opb),
        .o_busy  (w_busy),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    // EX -> MEM register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_bubble) begin
            r_alures_p1   <= '0;
            r_wdata_p1    <= '0;
            r_dest_p1     <= '0;
            r_zero_p1     <= 1'b0;
            r_branch_p1   <= 1'b0;
            r_memread_p1  <= 1'b0;
            r_memwrite_p1 <= 1'b0;
            r_regwrite_p1 <= 1'b0;
            r_memtoreg_p1 <= 1'b0;
        end else begin
            r_alures_p1   <= w_result;
            r_wdata_p1    <= RD2;
            r_dest_p1     <= RegDst ? rd : rt;
            r_zero_p1     <= (w_result == 32'd0);
            r_branch_p1   <= Branch_in;
            r_memread_p1  <= MemRead_in;
            r_memwrite_p1 <= MemWrite_in;
            r_regwrite_p1 <= RegWrite_in;
            r_memtoreg_p1 <= MemtoReg_in;
        end
    end

    assign ALUres_out = r_alures_p1;
    assign WriteData  = r_wdata_p1;
    assign des_Reg    = r_dest_p1;
    assign zero       = r_zero_p1;
    assign Branch     = r_branch_p1;
    assign MemRead    = r_memread_p1;
    assign MemWrite   = r_memwrite_p1;
    assign RegWrite   = r_regwrite_p1;
    assign MemtoReg   = r_memtoreg_p1;
    assign stall      = w_busy;

endmodule

// File: tb/tb_ex_cycle.sv
// Bench for ex_cycle: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ex_cycle;

    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111, C_NOR = 4'b1100, C_MULTU = 4'b1000, C_DIVU = 4'b1001;
    localparam logic [3:0] C_MFHI = 4'b1010, C_MFLO = 4'b1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD1, RD2, SignImm;
    logic [4:0]  rt, rd;
    logic        RegDst, ALUSrc;
    logic [3:0]  ALUControl;
    logic        MemRead_in, MemWrite_in, Branch_in, RegWrite_in, MemtoReg_in, flush;
    logic [31:0] ALUres_out, WriteData;
    logic [4:0]  des_Reg;
    logic        zero, Branch, MemRead, MemWrite, RegWrite, MemtoReg, stall;

    int n_checks = 0;
    int n_fail   = 0;

    ex_cycle dut (
        .clk(clk), .rst(rst), .RD1(RD1), .RD2(RD2), .SignImm(SignImm), .rt(rt), .rd(rd),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .flush(flush),
        .ALUres_out(ALUres_out), .WriteData(WriteData), .des_Reg(des_Reg), .zero(zero),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_alu = 0, m_wd = 0, m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    logic [4:0]  m_dst = 0;
    logic        m_zero = 0, m_stall = 0;
    logic [4:0]  m_ctl = 0;
    int          m_left = 0;

    always @(posedge clk or posedge rst) begin
        logic [31:0] b;
        logic [63:0] prod;
        if (rst) begin
            m_alu = 0; m_wd = 0; m_dst = 0; m_zero = 0; m_ctl = 0;
            m_hi = 0; m_lo = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_alu = 0; m_wd = 0; m_dst = 0; m_zero = 0; m_ctl = 0;
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else begin
            b = ALUSrc ? SignImm : RD2;
            if (flush || ALUControl == C_MULTU || ALUControl == C_DIVU) begin
                m_alu = 0; m_wd = 0; m_dst = 0; m_zero = 0; m_ctl = 0;
                if (!flush) begin
                    if (ALUControl == C_MULTU) begin
                        prod = 64'(RD1) * 64'(b);
                        p_hi = prod[63:32];
                        p_lo = prod[31:0];
                    end else if (b == 0) begin
                        p_lo = 32'hFFFF_FFFF;
                        p_hi = RD1;
                    end else begin
                        p_lo = RD1 / b;
                        p_hi = RD1 % b;
                    end
                    m_left = 32;
                end
            end else begin
                case (ALUControl)
                    C_AND:  m_alu = RD1 & b;
                    C_OR:   m_alu = RD1 | b;
                    C_ADD:  m_alu = RD1 + b;
                    C_SUB:  m_alu = RD1 - b;
                    C_SLT:  m_alu = ($signed(RD1) < $signed(b)) ? 1 : 0;
                    C_NOR:  m_alu = ~(RD1 | b);
                    C_MFHI: m_alu = m_hi;
                    C_MFLO: m_alu = m_lo;
                    default: m_alu = 0;
                endcase
                m_wd   = RD2;
                m_dst  = RegDst ? rd : rt;
                m_zero = (m_alu == 0);
                m_ctl  = {Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in};
            end
        end
        m_stall = (m_left > 0);
    end

    always @(negedge clk) begin
        check32("stall", 32'(stall), 32'(m_stall));
        check32("alures", ALUres_out, m_alu);
        check32("wdata", WriteData, m_wd);
        check32("dest", 32'(des_Reg), 32'(m_dst));
        check32("zero", 32'(zero), 32'(m_zero));
        check32("ctrl", 32'({Branch, MemRead, MemWrite, RegWrite, MemtoReg}), 32'(m_ctl));
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        RD1 = 0; RD2 = 0; SignImm = 0; rt = 0; rd = 0; RegDst = 0; ALUSrc = 0;
        ALUControl = C_AND; MemRead_in = 0; MemWrite_in = 0; Branch_in = 0;
        RegWrite_in = 0; MemtoReg_in = 0; flush = 0;
    endtask

    task automatic run_md(input string name, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic flush_mid,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        @(negedge clk);
        clear_in();
        RD1 = a; RD2 = b; ALUControl = code; RegWrite_in = 1;
        @(posedge clk); #1;
        check32({name, "_stall_on"}, 32'(stall), 32'd1);
        check32({name, "_bubble"}, 32'({RegWrite, MemWrite}), 32'd0);
        @(negedge clk);
        clear_in();
        ALUControl = C_ADD; RD1 = 1; RegWrite_in = 1; MemWrite_in = 1; flush = flush_mid;
        cnt = 0;
        while (stall === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check32({name, "_busy_cycles"}, cnt, 32'd32);
        clear_in();
        ALUControl = C_MFLO; RegWrite_in = 1; RegDst = 1; rd = 5;
        @(posedge clk); #1;
        check32({name, "_lo"}, ALUres_out, exp_lo);
        check32({name, "_mflo_regwrite"}, 32'(RegWrite), 32'd1);
        @(negedge clk);
        ALUControl = C_MFHI;
        @(posedge clk); #1;
        check32({name, "_hi"}, ALUres_out, exp_hi);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        rst = 1;
        clear_in();
        repeat (2) @(negedge clk);
        check32("reset_alures", ALUres_out, 32'd0);
        check32("reset_stall", 32'(stall), 32'd0);
        rst = 0;

        RD1 = 5; RD2 = 7; ALUControl = C_ADD; RegDst = 1; rd = 9; rt = 3; RegWrite_in = 1;
        @(posedge clk); #1;
        check32("add_res", ALUres_out, 32'd12);
        check32("add_dest", 32'(des_Reg), 32'd9);
        check32("add_zero", 32'(zero), 32'd0);

        @(negedge clk);
        clear_in();
        RD1 = 32'h1234; RD2 = 32'h1234; ALUControl = C_SUB; Branch_in = 1;
        @(posedge clk); #1;
        check32("beq_res", ALUres_out, 32'd0);
        check32("beq_zero", 32'(zero), 32'd1);
        check32("beq_branch", 32'(Branch), 32'd1);

        @(negedge clk);
        clear_in();
        RD1 = 32'hFFFF_FFFF; SignImm = 32'd1; ALUSrc = 1; ALUControl = C_SLT; rt = 4;
        @(posedge clk); #1;
        check32("slt_signed", ALUres_out, 32'd1);
        check32("slt_dest_rt", 32'(des_Reg), 32'd4);

        @(negedge clk);
        clear_in();
        RD1 = 32'h55; RD2 = 32'h66; ALUControl = 4'b0011;
        @(posedge clk); #1;
        check32("invalid_res", ALUres_out, 32'd0);
        check32("invalid_zero", 32'(zero), 32'd1);

        run_md("mul", C_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1, 32'hFFFF_FFFE);
        run_md("div0", C_DIVU, 32'd100, 32'd0, 1'b0, 32'd100, 32'hFFFF_FFFF);
        run_md("div7", C_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        run_md("mul_flush", C_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd1, 32'd0);

        @(negedge clk);
        clear_in();
        MemWrite_in = 1; RegWrite_in = 1; RD2 = 32'hABCD; flush = 1;
        @(posedge clk); #1;
        check32("flush_memwrite", 32'(MemWrite), 32'd0);
        check32("flush_regwrite", 32'(RegWrite), 32'd0);

        @(negedge clk);
        clear_in();
        RD1 = 3; RD2 = 4; ALUControl = C_MULTU; flush = 1;
        @(posedge clk); #1;
        check32("flush_no_start", 32'(stall), 32'd0);

        @(negedge clk);
        clear_in();
        RD1 = 7; RD2 = 9; ALUControl = C_MULTU;
        @(posedge clk);
        @(negedge clk);
        clear_in();
        repeat (10) @(posedge clk);
        #2 rst = 1;
        #1;
        check32("rst_mid_stall", 32'(stall), 32'd0);
        check32("rst_mid_alures", ALUres_out, 32'd0);
        check32("rst_mid_ctrl", 32'({Branch, MemRead, MemWrite, RegWrite, MemtoReg, zero}), 32'd0);
        @(negedge clk);
        rst = 0;
        RD1 = 3; RD2 = 4; ALUControl = C_ADD; RegDst = 1; rd = 17; RegWrite_in = 1;
        @(posedge clk); #1;
        check32("post_rst_add", ALUres_out, 32'd7);
        check32("post_rst_regwrite", 32'(RegWrite), 32'd1);
        @(negedge clk);
        ALUControl = C_MFHI;
        @(posedge clk); #1;
        check32("post_rst_hi", ALUres_out, 32'd0);
        @(negedge clk);
        ALUControl = C_MFLO;
        @(posedge clk); #1;
        check32("post_rst_lo", ALUres_out, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 5)       ALUControl = C_MULTU;
            else if (r < 10) ALUControl = C_DIVU;
            else if (r < 20) ALUControl = C_MFHI;
            else if (r < 30) ALUControl = C_MFLO;
            else if (r < 34) ALUControl = 4'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 5))
                    0: ALUControl = C_AND;
                    1: ALUControl = C_OR;
                    2: ALUControl = C_ADD;
                    3: ALUControl = C_SUB;
                    4: ALUControl = C_SLT;
                    default: ALUControl = C_NOR;
                endcase
            end
            RD1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 4))
                0: RD2 = 0;
                1: RD2 = 32'($urandom_range(1, 20));
                2: RD2 = RD1;
                default: RD2 = $urandom;
            endcase
            SignImm = {{16{1'b0}}, 16'($urandom)};
            if ($urandom_range(0, 1) == 1) SignImm = {{16{SignImm[15]}}, SignImm[15:0]};
            ALUSrc      = 1'($urandom_range(0, 3) == 0);
            RegDst      = 1'($urandom);
            rt          = 5'($urandom);
            rd          = 5'($urandom);
            MemRead_in  = 1'($urandom);
            MemWrite_in = 1'($urandom);
            Branch_in   = 1'($urandom);
            RegWrite_in = 1'($urandom);
            MemtoReg_in = 1'($urandom);
            flush       = 1'($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        clear_in();
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
